// File: rtl/muldiv_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes and FSM states.
package muldiv_unit_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } md_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_SIGN = 2'd2
  } md_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, subtract the divisor if it fits.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             dividend_bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_c_o,
  output logic             qbit_c_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    shifted  = {rem_i, dividend_bit_i};
    diff     = shifted - {1'b0, divisor_i};
    qbit_c_o = (shifted >= {1'b0, divisor_i});
    rem_c_o  = qbit_c_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: one bit per cycle on operand magnitudes, sign fix-up last.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam int unsigned W2    = 2 * WIDTH;

  md_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W2-1:0]    work_q, work_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] raw_a_q, raw_a_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             is_div_q, is_div_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dz_q, dz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             div0_q, div0_d;

  logic             signed_op, a_neg, b_neg, op_div;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [W2-1:0]    mul_next, div_next, prod_neg;
  logic [WIDTH-1:0] step_rem;
  logic             step_qbit;

  // Work register holds {acc, multiplier} for multiply and {remainder, dividend/quotient} for divide.
  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_i          (work_q[W2-1:WIDTH]),
    .dividend_bit_i (work_q[WIDTH-1]),
    .divisor_i      (opb_q),
    .rem_c_o        (step_rem),
    .qbit_c_o       (step_qbit)
  );

  always_comb begin
    mul_sum  = {1'b0, work_q[W2-1:WIDTH]} + (work_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
    mul_next = {mul_sum, work_q[WIDTH-1:1]};
    div_next = {step_rem, work_q[WIDTH-2:0], step_qbit};
    prod_neg = -work_q;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    opb_d     = opb_q;
    raw_a_d   = raw_a_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    div0_d    = div0_q;
    signed_op = (op == OP_MULT) || (op == OP_DIV);
    op_div    = (op == OP_DIV) || (op == OP_DIVU);
    a_neg     = signed_op & srca[WIDTH-1];
    b_neg     = signed_op & srcb[WIDTH-1];
    a_mag     = a_neg ? -srca : srca;
    b_mag     = b_neg ? -srcb : srcb;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !flush) begin
          case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              is_div_d  = op_div;
              neg_res_d = a_neg ^ b_neg;
              neg_rem_d = a_neg;
              dz_d      = op_div && (srcb == '0);
              work_d    = op_div ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
              opb_d     = op_div ? b_mag : a_mag;
              raw_a_d   = srca;
              cnt_d     = '0;
              div0_d    = 1'b0;
              state_d   = ST_CALC;
            end
            OP_MTHI: begin
              hi_d   = srca;
              done_d = 1'b1;
              div0_d = 1'b0;
            end
            OP_MTLO: begin
              lo_d   = srca;
              done_d = 1'b1;
              div0_d = 1'b0;
            end
            default: ;
          endcase
        end
      end
      ST_CALC: begin
        work_d = is_div_q ? div_next : mul_next;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = ST_SIGN;
      end
      ST_SIGN: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        if (dz_q) begin
          lo_d   = '1;
          hi_d   = raw_a_q;
          div0_d = 1'b1;
        end else if (is_div_q) begin
          lo_d = neg_res_q ? -work_q[WIDTH-1:0] : work_q[WIDTH-1:0];
          hi_d = neg_rem_q ? -work_q[W2-1:WIDTH] : work_q[W2-1:WIDTH];
        end else begin
          {hi_d, lo_d} = neg_res_q ? prod_neg : work_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Flush abandons the in-flight result entirely.
    if (flush && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
      div0_d  = div0_q;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      work_q    <= '0;
      opb_q     <= '0;
      raw_a_q   <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      opb_q     <= opb_d;
      raw_a_q   <= raw_a_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      div0_q    <= div0_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign div0 = div0_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at WIDTH=32; inputs change and outputs are sampled on the falling edge.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  op;
  logic [31:0] srca, srcb;
  logic        busy, done, div0;
  logic [31:0] hi, lo;
  int          n_cmp = 0;
  int          n_bad = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .srca(srca), .srcb(srcb),
    .flush(flush), .busy(busy), .done(done), .div0(div0), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Present a request at a falling edge, let one rising edge take it, return at the next falling edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; srca = a; srcb = b; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Rising edges from the acceptance edge until done is seen; 100 means it never came.
  task automatic wait_done(output int lat);
    int n = 0;
    while (n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (done) break;
    end
    lat = n;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 3'd0; srca = '0; srcb = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (hi !== 32'h0) begin n_bad++; $display("FAIL reset_hi: got %h want 0", hi); end
    n_cmp++; if (lo !== 32'h0) begin n_bad++; $display("FAIL reset_lo: got %h want 0", lo); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (div0 !== 1'b0) begin n_bad++; $display("FAIL reset_div0: got %b want 0", div0); end
  endtask

  task automatic test_mult();
    int lat;
    issue(OP_MULT, 32'hFFFF_FFFF, 32'h0000_0002);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mult_busy: got %b want 1", busy); end
    wait_done(lat);
    n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL mult_latency: got %0d want 33", lat); end
    n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
    n_cmp++; if (lo !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL mult_lo: got %h want fffffffe", lo); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mult_busy_end: got %b want 0", busy); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL mult_done_pulse: got %b want 0", done); end
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(lat);
    n_cmp++; if (hi !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL multu_hi: got %h want fffffffe", hi); end
    n_cmp++; if (lo !== 32'h0000_0001) begin n_bad++; $display("FAIL multu_lo: got %h want 00000001", lo); end
    issue(OP_MULT, 32'hFFFF_FFFD, 32'hFFFF_FFF9);
    wait_done(lat);
    n_cmp++; if ({hi, lo} !== 64'd21) begin n_bad++; $display("FAIL mult_negneg: got %h%h want 21", hi, lo); end
  endtask

  task automatic test_div();
    int lat;
    issue(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_done(lat);
    n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL div_latency: got %0d want 33", lat); end
    n_cmp++; if (lo !== 32'hFFFF_FFFD) begin n_bad++; $display("FAIL div_lo: got %h want fffffffd", lo); end
    n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL div_hi: got %h want ffffffff", hi); end
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(lat);
    n_cmp++; if (lo !== 32'h8000_0000) begin n_bad++; $display("FAIL divovf_lo: got %h want 80000000", lo); end
    n_cmp++; if (hi !== 32'h0) begin n_bad++; $display("FAIL divovf_hi: got %h want 0", hi); end
    issue(OP_DIVU, 32'd1000, 32'd7);
    wait_done(lat);
    n_cmp++; if (lo !== 32'd142) begin n_bad++; $display("FAIL divu_lo: got %0d want 142", lo); end
    n_cmp++; if (hi !== 32'd6) begin n_bad++; $display("FAIL divu_hi: got %0d want 6", hi); end
  endtask

  task automatic test_div0();
    int lat;
    issue(OP_DIVU, 32'h0000_0064, 32'h0);
    wait_done(lat);
    n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL div0_latency: got %0d want 33", lat); end
    n_cmp++; if (lo !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL div0_lo: got %h want ffffffff", lo); end
    n_cmp++; if (hi !== 32'h0000_0064) begin n_bad++; $display("FAIL div0_hi: got %h want 00000064", hi); end
    n_cmp++; if (div0 !== 1'b1) begin n_bad++; $display("FAIL div0_flag: got %b want 1", div0); end
    issue(OP_MTLO, 32'h1234_5678, 32'h0);
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL mtlo_done: got %b want 1", done); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mtlo_busy: got %b want 0", busy); end
    n_cmp++; if (lo !== 32'h1234_5678) begin n_bad++; $display("FAIL mtlo_lo: got %h want 12345678", lo); end
    n_cmp++; if (div0 !== 1'b0) begin n_bad++; $display("FAIL mtlo_div0_clear: got %b want 0", div0); end
    issue(OP_MTHI, 32'hAAAA_5555, 32'h0);
    n_cmp++; if (hi !== 32'hAAAA_5555) begin n_bad++; $display("FAIL mthi_hi: got %h want aaaa5555", hi); end
  endtask

  task automatic test_ignored();
    issue(3'd7, 32'hDEAD_BEEF, 32'h1);
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL undef_op: busy %b done %b want 0 0", busy, done); end
    n_cmp++; if (hi !== 32'hAAAA_5555) begin n_bad++; $display("FAIL undef_op_hi: got %h want aaaa5555", hi); end
    flush = 1'b1;
    issue(OP_MTHI, 32'hDEAD_BEEF, 32'h0);
    flush = 1'b0;
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL flush_start_done: got %b want 0", done); end
    n_cmp++; if (hi !== 32'hAAAA_5555) begin n_bad++; $display("FAIL flush_start_hi: got %h want aaaa5555", hi); end
  endtask

  task automatic test_flush();
    int lat;
    bit seen = 1'b0;
    issue(OP_MULT, 32'd3, 32'd5);
    for (int i = 0; i < 9; i++) begin
      if (done) seen = 1'b1;
      @(negedge clk);
    end
    flush = 1'b1;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    start = 1'b0;
    n_cmp++; if (seen || done !== 1'b0) begin n_bad++; $display("FAIL flush_done: got %b/%b want 0", seen, done); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL flush_busy: got %b want 0", busy); end
    n_cmp++; if (hi !== 32'hAAAA_5555 || lo !== 32'h1234_5678) begin n_bad++; $display("FAIL flush_hilo: got %h %h want aaaa5555 12345678", hi, lo); end
    issue(OP_MULTU, 32'd3, 32'd5);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL after_flush_accept: got %b want 1", busy); end
    wait_done(lat);
    n_cmp++; if (hi !== 32'd0 || lo !== 32'd15) begin n_bad++; $display("FAIL after_flush_result: got %h %h want 0 f", hi, lo); end
  endtask

  task automatic test_rst_mid();
    int lat;
    issue(OP_DIV, 32'd100, 32'd7);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if ({hi, lo, busy, done, div0} !== 67'd0) begin n_bad++; $display("FAIL rst_mid: got hi %h lo %h b%b d%b z%b want all 0", hi, lo, busy, done, div0); end
    issue(OP_DIVU, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    issue(OP_DIVU, 32'd1000, 32'd3);
    wait_done(lat);
    n_cmp++; if (lat > 33) begin n_bad++; $display("FAIL busy_start_timing: got %0d want <=33", lat); end
    n_cmp++; if (lo !== 32'd14 || hi !== 32'd2) begin n_bad++; $display("FAIL busy_start_ignored: got %0d r%0d want 14 r2", lo, hi); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div0();
    test_ignored();
    test_flush();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
